// File: rtl/ram_share_pkg.sv
// Shared types and constants for the SRAM port arbiter between the SPI RAM loader and the core.
package ram_share_pkg;

  localparam int unsigned MemAddrWidth = 32;
  localparam int unsigned MemDataWidth = 32;
  localparam int unsigned MemBeWidth   = MemDataWidth / 8;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic                    req;
    logic                    we;
    logic [MemBeWidth-1:0]   be;
    logic [MemAddrWidth-1:0] addr;
    logic [MemDataWidth-1:0] wdata;
  } mem_req_t;

  localparam logic OwnerCore = 1'b0;
  localparam logic OwnerLd   = 1'b1;

endpackage

// File: rtl/ram_share_hold_cnt.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
module ram_share_hold_cnt #(
  parameter int unsigned      Width    = 4,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_share_arbiter.sv
// Shares one SRAM port between the SPI loader and the core data port, and holds the
// core in reset around load sessions.
module ram_share_arbiter
  import ram_share_pkg::*;
#(
  parameter int unsigned AddrWidth  = MemAddrWidth,
  parameter int unsigned DataWidth  = MemDataWidth,
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   ld_start_i,
  input  logic                   ld_done_i,
  input  logic                   ld_req_i,
  input  logic                   ld_we_i,
  input  logic [DataWidth/8-1:0] ld_be_i,
  input  logic [AddrWidth-1:0]   ld_addr_i,
  input  logic [DataWidth-1:0]   ld_wdata_i,
  output logic                   ld_gnt_o,
  output logic                   ld_rvalid_o,
  output logic [DataWidth-1:0]   ld_rdata_o,
  input  logic                   core_req_i,
  input  logic                   core_we_i,
  input  logic [DataWidth/8-1:0] core_be_i,
  input  logic [AddrWidth-1:0]   core_addr_i,
  input  logic [DataWidth-1:0]   core_wdata_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  output logic [DataWidth-1:0]   core_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   core_rst_no,
  output logic                   load_busy_o,
  output logic [CntWidth-1:0]    load_words_o
);

  localparam int unsigned HoldWidth = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [HoldWidth-1:0] HoldInit = HoldWidth'(HoldCycles - 1);

  state_e              state_q, state_d;
  logic                core_rst_n_q;
  logic                load_busy_q;
  logic                owner_q;
  logic [CntWidth-1:0] load_words_q, load_words_d;
  logic                hold_load, hold_dec, hold_zero;
  logic                ld_gnt, core_gnt;
  mem_req_t            ld_bus, core_bus, mem_bus;

  // The counter sits at HoldInit whenever we are outside HOLD, so every HOLD entry
  // starts a full HoldCycles window.
  assign hold_load = (state_q != ST_HOLD);
  assign hold_dec  = (state_q == ST_HOLD);

  ram_share_hold_cnt #(
    .Width    (HoldWidth),
    .ResetVal (HoldInit)
  ) u_hold_cnt (
    .clk_i      (clk_sys_i),
    .rst_i      (rst_sys_i),
    .load_i     (hold_load),
    .load_val_i (HoldInit),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: if (hold_zero) state_d = ST_RUN;
      ST_LOAD: if (ld_done_i) state_d = ST_HOLD;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HOLD;
    endcase
    // A new session always wins, including over a same-cycle ld_done_i.
    if (ld_start_i) state_d = ST_LOAD;
  end

  assign ld_gnt   = ld_req_i;
  assign core_gnt = (state_q == ST_RUN) & core_req_i & ~ld_req_i;

  always_comb begin
    ld_bus.req     = ld_req_i;
    ld_bus.we      = ld_we_i;
    ld_bus.be      = ld_be_i;
    ld_bus.addr    = ld_addr_i;
    ld_bus.wdata   = ld_wdata_i;
    core_bus.req   = core_req_i;
    core_bus.we    = core_we_i;
    core_bus.be    = core_be_i;
    core_bus.addr  = core_addr_i;
    core_bus.wdata = core_wdata_i;
    mem_bus        = ld_req_i ? ld_bus : core_bus;
    mem_bus.req    = ld_gnt | core_gnt;
  end

  always_comb begin
    load_words_d = load_words_q;
    if (ld_start_i) begin
      load_words_d = '0;
    end else if ((state_q == ST_LOAD) && ld_gnt && ld_we_i && (load_words_q != '1)) begin
      load_words_d = load_words_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q      <= ST_HOLD;
      core_rst_n_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_words_q <= '0;
      owner_q      <= OwnerCore;
    end else begin
      state_q      <= state_d;
      core_rst_n_q <= (state_d == ST_RUN);
      load_busy_q  <= (state_d == ST_LOAD);
      load_words_q <= load_words_d;
      if (mem_bus.req) begin
        owner_q <= ld_gnt ? OwnerLd : OwnerCore;
      end
    end
  end

  assign ld_gnt_o      = ld_gnt;
  assign core_gnt_o    = core_gnt;
  assign mem_req_o     = mem_bus.req;
  assign mem_we_o      = mem_bus.we;
  assign mem_be_o      = mem_bus.be;
  assign mem_addr_o    = mem_bus.addr;
  assign mem_wdata_o   = mem_bus.wdata;

  // Responses follow the recorded owner, so one in flight across a state change lands correctly.
  assign ld_rvalid_o   = mem_rvalid_i & (owner_q == OwnerLd);
  assign core_rvalid_o = mem_rvalid_i & (owner_q == OwnerCore);
  assign ld_rdata_o    = mem_rdata_i;
  assign core_rdata_o  = mem_rdata_i;

  assign core_rst_no   = core_rst_n_q;
  assign load_busy_o   = load_busy_q;
  assign load_words_o  = load_words_q;

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Self-checking bench for ram_share_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the sharing and reset-sequencing rules.
module tb_ram_share_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int HC = 16;
  localparam int CW = 16;

  localparam int PH_HOLD = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_start = 0, ld_done = 0, ld_req = 0, ld_we = 0;
  logic [BW-1:0] ld_be = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt, ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          core_req = 0, core_we = 0;
  logic [BW-1:0] core_be = '0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          core_rst_n, load_busy;
  logic [CW-1:0] load_words;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_share_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .HoldCycles(HC), .CntWidth(CW)
  ) dut (
    .clk_sys_i(clk), .rst_sys_i(rst),
    .ld_start_i(ld_start), .ld_done_i(ld_done),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_be_i(ld_be), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .core_rst_no(core_rst_n), .load_busy_o(load_busy), .load_words_o(load_words)
  );

  // SRAM stub: 64 words, one-cycle read latency, byte-enabled writes.
  logic [DW-1:0] sram [0:63];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      for (int i = 0; i < 64; i++) sram[i] <= 32'hA500_0000 ^ (i * 32'h0001_0203);
    end else begin
      mem_rvalid <= mem_req;
      if (mem_req) begin
        if (mem_we) begin
          for (int b = 0; b < BW; b++)
            if (mem_be[b]) sram[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end else begin
          mem_rdata <= sram[mem_addr[7:2]];
        end
      end
    end
  end

  // Reference model: phase, remaining hold cycles, session word count, pending response.
  int            m_phase;
  int            m_hold_left;
  int            m_words;
  bit            m_pend, m_pend_ld, m_pend_rd;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] ref_mem [0:63];

  task automatic model_reset();
    m_phase     = PH_HOLD;
    m_hold_left = HC;
    m_words     = 0;
    m_pend      = 0;
    m_pend_ld   = 0;
    m_pend_rd   = 0;
    m_pend_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
  endtask

  function automatic bit exp_core_gnt();
    return (m_phase == PH_RUN) && core_req && !ld_req;
  endfunction

  // Called just after a rising edge, while the inputs still hold their pre-edge values.
  task automatic model_update();
    bit            req, we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            idx;
    req  = ld_req || exp_core_gnt();
    we   = ld_req ? ld_we : core_we;
    be   = ld_req ? ld_be : core_be;
    addr = ld_req ? ld_addr : core_addr;
    wd   = ld_req ? ld_wdata : core_wdata;
    m_pend    = req;
    m_pend_ld = ld_req;
    m_pend_rd = !we;
    if (req) begin
      idx = int'(addr[7:2]);
      if (!we) m_pend_data = ref_mem[idx];
      else for (int b = 0; b < BW; b++) if (be[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    if (ld_start) m_words = 0;
    else if (m_phase == PH_LOAD && ld_req && ld_we && m_words < (1 << CW) - 1) m_words++;
    if (ld_start) begin
      m_phase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      if (ld_done) begin
        m_phase     = PH_HOLD;
        m_hold_left = HC;
      end
    end else if (m_phase == PH_HOLD) begin
      m_hold_left--;
      if (m_hold_left == 0) m_phase = PH_RUN;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    ld_start = 0; ld_done = 0; ld_req = 0; ld_we = 0; ld_be = '0; ld_addr = '0; ld_wdata = '0;
    core_req = 0; core_we = 0; core_be = '0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_req = 1; ld_we = 1; ld_be = 4'hF; ld_addr = a; ld_wdata = d;
  endtask

  task automatic core_read(input logic [AW-1:0] a);
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = a;
  endtask

  // Counts cycles with core reset still asserted; returns 40 if RUN is never reached.
  task automatic wait_run(output int n_low);
    n_low = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      #1;
      if (core_rst_n === 1'b1) break;
      n_low++;
      advance();
    end
  endtask

  task automatic test_reset();
    int n_low;
    idle();
    #2 rst = 1;
    #1;
    n_checks++;
    if ({core_rst_n, load_busy, load_words, ld_gnt, core_gnt, ld_rvalid, core_rvalid} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rst_n=%b busy=%b words=%0d gnt=%b%b rv=%b%b required all 0",
               core_rst_n, load_busy, load_words, ld_gnt, core_gnt, ld_rvalid, core_rvalid);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    wait_run(n_low);
    n_checks++;
    if (n_low !== HC) begin
      n_fail++;
      $display("FAIL reset_hold_len: got %0d cycles required %0d", n_low, HC);
    end
    core_read(32'h100);
    #1;
    n_checks++;
    if (core_gnt !== 1'b1 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL run_core_gnt: got gnt=%b addr=%h required gnt=1 addr=00000100", core_gnt, mem_addr);
    end
    $display("txn reset_release: hold %0d cycles, core read 0x100 granted=%b", n_low, core_gnt);
    advance();
    idle();
  endtask

  task automatic test_priority();
    ld_req = 1; ld_we = 0; ld_be = 4'hF; ld_addr = 32'h40;
    core_read(32'h100);
    #1;
    n_checks++;
    if (ld_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL priority: got ld_gnt=%b core_gnt=%b addr=%h required 1 0 00000040",
               ld_gnt, core_gnt, mem_addr);
    end
    advance();
    ld_req = 0;
    #1;
    n_checks++;
    if (core_gnt !== 1'b1 || ld_rvalid !== 1'b1 || core_rvalid !== 1'b0 || ld_rdata !== m_pend_data) begin
      n_fail++;
      $display("FAIL priority_next: got core_gnt=%b ld_rv=%b core_rv=%b rdata=%h required 1 1 0 %h",
               core_gnt, ld_rvalid, core_rvalid, ld_rdata, m_pend_data);
    end
    $display("txn priority: loader read 0x40 then core read 0x100");
    advance();
    idle();
    #1;
    n_checks++;
    if (core_rvalid !== 1'b1 || ld_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL priority_core_rv: got core_rv=%b ld_rv=%b required 1 0", core_rvalid, ld_rvalid);
    end
    advance();
  endtask

  task automatic test_load();
    int n_low;
    idle();
    ld_start = 1;
    advance();
    idle();
    #1;
    n_checks++;
    if (core_rst_n !== 1'b0 || load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_enter: got rst_n=%b busy=%b required 0 1", core_rst_n, load_busy);
    end
    for (int i = 0; i < 4; i++) begin
      ld_write(AW'(i * 4), 32'hC0DE_0000 + DW'(i));
      core_read(32'h30);
      #1;
      n_checks++;
      if (core_gnt !== 1'b0 || ld_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL load_gnt: got core_gnt=%b ld_gnt=%b required 0 1", core_gnt, ld_gnt);
      end
      $display("txn load_write: addr=%h data=%h", ld_addr, ld_wdata);
      advance();
      idle();
    end
    ld_done = 1;
    core_read(32'h30);
    #1;
    n_checks++;
    if (core_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done_gnt: got core_gnt=%b required 0", core_gnt);
    end
    advance();
    idle();
    #1;
    n_checks++;
    if (load_words !== 16'd4 || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_words: got words=%0d busy=%b required 4 0", load_words, load_busy);
    end
    wait_run(n_low);
    n_checks++;
    if (n_low !== HC) begin
      n_fail++;
      $display("FAIL load_hold_len: got %0d cycles required %0d", n_low, HC);
    end
    core_read(32'h8);
    advance();
    idle();
    #1;
    n_checks++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hC0DE_0002) begin
      n_fail++;
      $display("FAIL load_readback: got rv=%b data=%h required 1 c0de0002", core_rvalid, core_rdata);
    end
    advance();
  endtask

  task automatic test_resp_across();
    int n_low;
    idle();
    core_read(32'h20);
    #1;
    n_checks++;
    if (core_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL across_gnt: got core_gnt=%b required 1", core_gnt);
    end
    advance();
    idle();
    ld_start = 1;
    #1;
    n_checks++;
    if (core_rvalid !== 1'b1 || ld_rvalid !== 1'b0 || core_rdata !== ref_mem[8]) begin
      n_fail++;
      $display("FAIL across_route: got core_rv=%b ld_rv=%b data=%h required 1 0 %h",
               core_rvalid, ld_rvalid, core_rdata, ref_mem[8]);
    end
    advance();
    idle();
    ld_done = 1;
    advance();
    wait_run(n_low);
    // Core read granted on the same edge that enters LOAD: its response lands in the first LOAD cycle.
    core_read(32'h24);
    ld_start = 1;
    #1;
    n_checks++;
    if (core_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL across2_gnt: got core_gnt=%b required 1", core_gnt);
    end
    advance();
    idle();
    #1;
    n_checks++;
    if (core_rvalid !== 1'b1 || ld_rvalid !== 1'b0 || load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL across2_route: got core_rv=%b ld_rv=%b busy=%b required 1 0 1",
               core_rvalid, ld_rvalid, load_busy);
    end
    $display("txn resp_across: core reads 0x20/0x24 routed to core across LOAD entry");
    ld_done = 1;
    advance();
    wait_run(n_low);
  endtask

  task automatic test_start_done_same();
    int n_low;
    idle();
    ld_start = 1;
    advance();
    for (int i = 0; i < 2; i++) begin
      idle();
      ld_write(AW'(32'h50 + i * 4), DW'($urandom));
      advance();
    end
    idle();
    ld_start = 1;
    ld_done  = 1;
    advance();
    idle();
    #1;
    n_checks++;
    if (load_busy !== 1'b1 || load_words !== 16'd0) begin
      n_fail++;
      $display("FAIL start_done_same: got busy=%b words=%0d required 1 0", load_busy, load_words);
    end
    ld_write(32'h60, 32'h1234_5678);
    advance();
    idle();
    #1;
    n_checks++;
    if (load_words !== 16'd1) begin
      n_fail++;
      $display("FAIL start_done_count: got words=%0d required 1", load_words);
    end
    $display("txn start_done_same: session restarted, words=%0d", load_words);
    ld_done = 1;
    advance();
    wait_run(n_low);
    n_checks++;
    if (n_low !== HC) begin
      n_fail++;
      $display("FAIL start_done_hold: got %0d cycles required %0d", n_low, HC);
    end
  endtask

  task automatic test_random();
    int            errs;
    logic [DW-1:0] e_rdata;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      ld_start   = ($urandom_range(0, 99) < 3);
      ld_done    = ($urandom_range(0, 99) < 8);
      ld_req     = ($urandom_range(0, 99) < 40);
      ld_we      = $urandom_range(0, 1);
      ld_be      = BW'($urandom_range(0, 15));
      ld_addr    = AW'($urandom_range(0, 15) * 4);
      ld_wdata   = DW'($urandom);
      core_req   = ($urandom_range(0, 99) < 50);
      core_we    = $urandom_range(0, 1);
      core_be    = BW'($urandom_range(0, 15));
      core_addr  = AW'($urandom_range(0, 15) * 4);
      core_wdata = DW'($urandom);
      #1;
      errs = 0;
      e_rdata = m_pend_data;
      n_checks++;
      if (ld_gnt !== ld_req || core_gnt !== exp_core_gnt() || mem_req !== (ld_req || exp_core_gnt())) begin
        errs++;
        $display("FAIL rand_gnt cyc %0d: got ld=%b core=%b mem=%b required %b %b %b", cyc,
                 ld_gnt, core_gnt, mem_req, ld_req, exp_core_gnt(), ld_req || exp_core_gnt());
      end
      n_checks++;
      if (mem_req === 1'b1 &&
          ({mem_we, mem_be, mem_addr, mem_wdata} !==
           (ld_req ? {ld_we, ld_be, ld_addr, ld_wdata} : {core_we, core_be, core_addr, core_wdata}))) begin
        errs++;
        $display("FAIL rand_mux cyc %0d: got addr=%h we=%b required from %s", cyc, mem_addr, mem_we,
                 ld_req ? "loader" : "core");
      end
      n_checks++;
      if (ld_rvalid !== (m_pend && m_pend_ld) || core_rvalid !== (m_pend && !m_pend_ld)) begin
        errs++;
        $display("FAIL rand_rvalid cyc %0d: got ld=%b core=%b required %b %b", cyc, ld_rvalid,
                 core_rvalid, m_pend && m_pend_ld, m_pend && !m_pend_ld);
      end
      n_checks++;
      if (m_pend && m_pend_rd && (ld_rdata !== e_rdata || core_rdata !== e_rdata)) begin
        errs++;
        $display("FAIL rand_rdata cyc %0d: got %h/%h required %h", cyc, ld_rdata, core_rdata, e_rdata);
      end
      n_checks++;
      if (core_rst_n !== (m_phase == PH_RUN) || load_busy !== (m_phase == PH_LOAD) ||
          load_words !== CW'(m_words)) begin
        errs++;
        $display("FAIL rand_status cyc %0d: got rst_n=%b busy=%b words=%0d required %b %b %0d", cyc,
                 core_rst_n, load_busy, load_words, m_phase == PH_RUN, m_phase == PH_LOAD, m_words);
      end
      n_fail += errs;
      if (mem_req === 1'b1)
        $display("txn rand cyc %0d: %s %s addr=%h", cyc, ld_req ? "loader" : "core",
                 mem_we ? "write" : "read", mem_addr);
      advance();
    end
    idle();
  endtask

  task automatic test_reset_mid_load();
    int n_low;
    idle();
    ld_start = 1;
    advance();
    for (int i = 0; i < 3; i++) begin
      idle();
      ld_write(AW'(i * 4 + 32'h70), DW'($urandom));
      advance();
    end
    idle();
    #1;
    n_checks++;
    if (load_words !== 16'd3 || load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_pre: got words=%0d busy=%b required 3 1", load_words, load_busy);
    end
    rst = 1;
    #1;
    n_checks++;
    if ({core_rst_n, load_busy, load_words, ld_gnt, core_gnt, ld_rvalid, core_rvalid} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: got rst_n=%b busy=%b words=%0d rv=%b%b required all 0",
               core_rst_n, load_busy, load_words, ld_rvalid, core_rvalid);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    #1;
    n_checks++;
    if (load_busy !== 1'b0 || load_words !== 16'd0 || core_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_release: got busy=%b words=%0d rst_n=%b required 0 0 0",
               load_busy, load_words, core_rst_n);
    end
    wait_run(n_low);
    n_checks++;
    if (n_low !== HC) begin
      n_fail++;
      $display("FAIL midload_hold: got %0d cycles required %0d", n_low, HC);
    end
    $display("txn reset_mid_load: aborted after 3 writes, hold %0d cycles", n_low);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_load();
    test_resp_across();
    test_start_done_same();
    test_random();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_share_arbiter.md
Name: ram_share_arbiter

Overview:
- Shares the single SRAM port between the SPI RAM loader and the Ibex core data port, and sequences core reset around load sessions.
- Sits between the SPI RAM-configurator datapath, the core-side memory request bus and the SRAM.
- During a load session the core is held in reset and only the loader is granted. After `ld_done_i` the core is released after a fixed hold.
- In RUN the loader may still poke memory, with priority over the core.

Parameters:
- AddrWidth, 32, address width of all three ports
- DataWidth, 32, data width; byte-enable width is DataWidth/8
- HoldCycles, 16, cycles core reset stays asserted after reset or after a load ends (>=1)
- CntWidth, 16, width of the load word counter

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_i  in  1  reset, asynchronous, active-high
- ld_start_i  in  1  pulse: loader session begins
- ld_done_i  in  1  pulse: loader session ends
- ld_req_i  in  1  loader request
- ld_we_i  in  1  loader write enable
- ld_be_i  in  DataWidth/8  loader byte enables
- ld_addr_i  in  AddrWidth  loader address
- ld_wdata_i  in  DataWidth  loader write data
- ld_gnt_o  out  1  loader grant
- ld_rvalid_o  out  1  loader read response valid
- ld_rdata_o  out  DataWidth  loader read data
- core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i  in  same widths as loader  core request bus
- core_gnt_o  out  1  core grant
- core_rvalid_o  out  1  core response valid
- core_rdata_o  out  DataWidth  core read data
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  same widths  SRAM request
- mem_rvalid_i  in  1  SRAM response, exactly 1 cycle after an accepted mem_req_o
- mem_rdata_i  in  DataWidth  SRAM read data
- core_rst_no  out  1  core reset, active-low, registered
- load_busy_o  out  1  high while in LOAD
- load_words_o  out  CntWidth  loader writes accepted in the current or last session

Behaviour:
- FSM states: HOLD, LOAD, RUN.
- Reset state is HOLD with hold counter = HoldCycles-1.
- Reset values: core_rst_no=0, load_busy_o=0, load_words_o=0, owner flop=0 (core), all gnt and rvalid outputs 0.
- HOLD:
  - Counter decrements each cycle; at 0, next state is RUN, so HOLD lasts exactly HoldCycles cycles.
  - Only the loader may be granted.
- LOAD:
  - Entered from any state on ld_start_i. The hold counter is reloaded on exit.
  - Only the loader may be granted.
  - ld_done_i moves the FSM to HOLD with counter = HoldCycles-1.
- RUN:
  - Both requesters may be granted; the loader has fixed priority.
  - core_gnt_o = core_req_i & ~ld_req_i.
- Simultaneous ld_start_i and ld_done_i: ld_start_i wins; the FSM enters or stays in LOAD.
- ld_done_i outside LOAD is ignored.
- Grant is combinational in the same cycle:
  - ld_gnt_o = ld_req_i in all states.
  - core_gnt_o = 0 outside RUN.
  - mem_req_o = ld_gnt_o | core_gnt_o.
  - mem_* fields are muxed from the loader when ld_req_i=1, otherwise from the core.
- Response routing:
  - The owner flop captures "loader granted" on every cycle mem_req_o=1.
  - mem_rvalid_i is steered to ld_rvalid_o or core_rvalid_o by the owner flop; the other rvalid stays 0.
  - rdata is passed to both outputs unmodified.
  - A response outstanding across a state change still goes to its recorded owner, including a core response arriving in the first LOAD cycle.
- core_rst_no:
  - Registered: next value = (next_state == RUN).
  - Goes high on the clock edge that enters RUN and falls on the edge that leaves RUN.
  - Glitch-free.
- load_busy_o: registered, equals (state == LOAD).
- load_words_o:
  - Cleared on ld_start_i.
  - Increments on each cycle with ld_gnt_o & ld_we_i while in LOAD.
  - Saturates at all-ones.
  - Held after the session ends.
- An asynchronous reset mid-session aborts the load; the block returns to HOLD and the counter clears.

Decomposition:
- Package ram_share_pkg holds:
  - the state enum typedef (HOLD, LOAD, RUN)
  - the mem request struct typedef (req, we, be, addr, wdata)
  - the owner encoding constants
- One sub-module, ram_share_hold_cnt: a loadable down-counter with a zero flag, used for the HoldCycles timing.

Test Plan:
- Reset release, no load, HoldCycles=16 -> core_rst_no=0 for 16 cycles then 1; core_req with addr 0x100 gets core_gnt_o the same cycle.
- ld_start pulse in RUN, then 4 loader writes (addr 0x0..0xC, be=0xF) and ld_done -> core_rst_no falls on the next edge; core_gnt_o=0 throughout LOAD; load_words_o=4; core_rst_no rises 16 cycles after ld_done.
- RUN with ld_req and core_req asserted in the same cycle -> ld_gnt_o=1, core_gnt_o=0, mem_addr_o = loader address; the core is granted the next cycle once ld_req drops.
- Core read of 0x20 granted, then ld_start the next cycle -> the rvalid one cycle later appears on core_rvalid_o, not ld_rvalid_o.
- ld_start and ld_done in the same cycle while in LOAD -> stays in LOAD, load_words_o cleared to 0.
- rst_sys_i asserted mid-LOAD after 3 writes -> all outputs at reset values immediately; after release the FSM is in HOLD and load_words_o=0.
